// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage.
//   XLEN              : architectural data/address width.
//   RESET_PC_DEFAULT  : default address of the first fetch after reset.
//   fetch_state_e     : fetch control states (S_RUN, S_DROP).
//   fetch_entry_t     : one buffered fetch result {pc, instr}.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_DROP = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory bus between the fetch unit and instruction memory.
//   IMem_Req  : request valid (held until acknowledged).
//   IMem_Addr : word-aligned fetch address, stable while IMem_Req is high.
//   IMem_Ack  : completes the outstanding request in this cycle.
//   IMem_Data : instruction word, meaningful only while IMem_Ack is high.
// master = fetch unit, slave = memory.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic            IMem_Req;
  logic [XLEN-1:0] IMem_Addr;
  logic            IMem_Ack;
  logic [XLEN-1:0] IMem_Data;

  modport master (
    output IMem_Req,
    output IMem_Addr,
    input  IMem_Ack,
    input  IMem_Data
  );

  modport slave (
    input  IMem_Req,
    input  IMem_Addr,
    output IMem_Ack,
    output IMem_Data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry buffer of fetched {pc, instr} words.
//   i_Clk, i_Rst : clock, synchronous active-high reset.
//   push/wr_data : append an entry (never issued while full).
//   pop          : drop the head entry (ignored while empty).
//   flush        : empty the buffer; wins over push and pop.
//   head         : registered head entry, all zeros while empty.
//   count        : number of live entries (0..2).
module fetch_fifo
  import cpu_pkg::*;
(
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t tail;
  logic         do_pop;

  assign do_pop = pop && (count != 2'd0);

  always_ff @(posedge i_Clk) begin
    if (i_Rst || flush) begin
      count <= 2'd0;
      head  <= '0;
    end else begin
      case ({push, do_pop})
        2'b11: begin
          // Count unchanged: the new word lands behind whatever remains.
          if (count == 2'd1) begin
            head <= wr_data;
          end else begin
            head <= tail;
            tail <= wr_data;
          end
        end
        2'b10: begin
          if (count == 2'd0) head <= wr_data;
          else               tail <= wr_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          // Clear the head when the last entry leaves so it reads zero.
          if (count == 2'd1) head <= '0;
          else               head <= tail;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register.
//   RESET_PC      : address of the first fetch after reset (word aligned).
//   i_Clk, i_Rst  : clock, synchronous active-high reset.
//   imem          : instruction memory bus (single outstanding request).
//   i_Stall       : IF/ID register is not loading this cycle.
//   i_Redirect    : taken branch/jump from execute, with target i_RedirectPC.
//   o_Valid/o_Instr/o_PC/o_PCPlus4 : head of the fetch buffer for IF/ID.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  fetch_unit_if.master      imem,
  input  logic              i_Stall,
  input  logic              i_Redirect,
  input  logic [XLEN-1:0]   i_RedirectPC,
  output logic              o_Valid,
  output logic [XLEN-1:0]   o_Instr,
  output logic [XLEN-1:0]   o_PC,
  output logic [XLEN-1:0]   o_PCPlus4
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] next_pc, next_pc_nxt;
  logic [XLEN-1:0] pc_base;
  logic            req_q, req_nxt;
  logic [XLEN-1:0] addr_q, addr_nxt;
  logic            keep_out, push, pop, issue;
  logic [1:0]      count, count_nxt;
  fetch_entry_t    head, wr_entry;

  assign imem.IMem_Req  = req_q;
  assign imem.IMem_Addr = addr_q;

  always_comb begin
    state_nxt   = state;
    next_pc_nxt = next_pc;
    req_nxt     = req_q;
    addr_nxt    = addr_q;

    // A request still in flight after this edge blocks any new issue.
    keep_out = req_q && !imem.IMem_Ack;
    push     = req_q && imem.IMem_Ack && (state == S_RUN) && !i_Redirect;
    pop      = (count != 2'd0) && !i_Stall && !i_Redirect;
    pc_base  = i_Redirect ? {i_RedirectPC[XLEN-1:2], 2'b00} : next_pc;

    if (i_Redirect) count_nxt = 2'd0;
    else            count_nxt = count + {1'b0, push} - {1'b0, pop};

    // Issuing only when at most one entry remains guarantees room for the return.
    issue = !keep_out && (count_nxt <= 2'd1);

    if (keep_out) state_nxt = i_Redirect ? S_DROP : state;
    else          state_nxt = S_RUN;

    if (issue) begin
      req_nxt     = 1'b1;
      addr_nxt    = pc_base;
      next_pc_nxt = pc_base + 32'd4;
    end else begin
      next_pc_nxt = pc_base;
      if (!keep_out) req_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= S_RUN;
      next_pc <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      state   <= state_nxt;
      next_pc <= next_pc_nxt;
      req_q   <= req_nxt;
      addr_q  <= addr_nxt;
    end
  end

  assign wr_entry = '{pc: addr_q, instr: imem.IMem_Data};

  fetch_fifo u_fifo (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .push    (push),
    .pop     (pop),
    .flush   (i_Redirect),
    .wr_data (wr_entry),
    .head    (head),
    .count   (count)
  );

  assign o_Valid   = (count != 2'd0);
  assign o_Instr   = head.instr;
  assign o_PC      = head.pc;
  assign o_PCPlus4 = head.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, redir;
  logic [31:0] rpc;
  logic        valid;
  logic [31:0] instr, pc, pc4;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .imem         (bus),
    .i_Stall      (stall),
    .i_Redirect   (redir),
    .i_RedirectPC (rpc),
    .o_Valid      (valid),
    .o_Instr      (instr),
    .o_PC         (pc),
    .o_PCPlus4    (pc4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  // Reference: buffered stream as a queue, program-order fetch address,
  // and a memory that answers each request after a chosen latency.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_fetch_pc;
  bit          mem_busy = 0;
  bit          mem_drop = 0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 0;
  int          lat_mode = 0;
  bit          exp_req  = 0;
  int          pops     = 0;

  task automatic tick(bit r, bit s, bit d, logic [31:0] t);
    bit ack_now;
    bit do_pop;
    @(negedge clk);
    rst = r; stall = s; redir = d; rpc = t;
    ack_now = 0;
    if (bus.IMem_Req === 1'b1) begin
      if (!mem_busy) begin
        check("issue_addr", bus.IMem_Addr, exp_fetch_pc);
        exp_fetch_pc = exp_fetch_pc + 32'd4;
        mem_busy = 1;
        mem_drop = 0;
        mem_addr = bus.IMem_Addr;
        mem_cnt  = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
      end else begin
        check("addr_stable", bus.IMem_Addr, mem_addr);
      end
      if (mem_cnt == 0) ack_now = 1;
      else              mem_cnt--;
    end
    bus.IMem_Ack  = ack_now;
    bus.IMem_Data = ack_now ? mem_word(mem_addr) : $urandom;

    if (r) begin
      q.delete();
      exp_fetch_pc = RST_PC;
      mem_busy = 0;
      exp_req  = 0;
    end else begin
      do_pop = (q.size() > 0) && !s && !d;
      if (d) begin
        q.delete();
        exp_fetch_pc = {t[31:2], 2'b00};
        if (mem_busy && !ack_now) mem_drop = 1;
      end else begin
        if (do_pop) begin
          q.delete(0);
          pops++;
        end
        if (ack_now && !mem_drop) q.push_back('{mem_addr, mem_word(mem_addr)});
      end
      if (ack_now) mem_busy = 0;
      exp_req = mem_busy || (q.size() <= 1);
    end

    @(posedge clk);
    #1;
    check("req", bus.IMem_Req, exp_req);
    check("valid", valid, q.size() > 0);
    if (q.size() > 0) begin
      check("pc", pc, q[0].pc);
      check("instr", instr, q[0].instr);
      check("pc4", pc4, q[0].pc + 32'd4);
    end else begin
      check("pc_empty", pc, 32'h0);
      check("instr_empty", instr, 32'h0);
      check("pc4_empty", pc4, 32'h4);
    end
  endtask

  typedef struct {
    bit          r, s, d;
    logic [31:0] t;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t tbl[17];

  initial begin
    rst = 1; stall = 0; redir = 0; rpc = 0;
    bus.IMem_Ack = 0; bus.IMem_Data = 0;
    exp_fetch_pc = RST_PC;

    // Zero-wait memory: reset, sequential fetch, stall, redirects, wrap.
    tbl[0]  = '{1, 0, 0, 32'h0,         0, 32'h100,       0, 32'h0,         32'h4};
    tbl[1]  = '{1, 0, 0, 32'h0,         0, 32'h100,       0, 32'h0,         32'h4};
    tbl[2]  = '{0, 0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         32'h4};
    tbl[3]  = '{0, 0, 0, 32'h0,         1, 32'h104,       1, 32'h100,       32'h104};
    tbl[4]  = '{0, 0, 0, 32'h0,         1, 32'h108,       1, 32'h104,       32'h108};
    tbl[5]  = '{0, 1, 0, 32'h0,         0, 32'h108,       1, 32'h104,       32'h108};
    tbl[6]  = '{0, 1, 0, 32'h0,         0, 32'h108,       1, 32'h104,       32'h108};
    tbl[7]  = '{0, 1, 0, 32'h0,         0, 32'h108,       1, 32'h104,       32'h108};
    tbl[8]  = '{0, 1, 0, 32'h0,         0, 32'h108,       1, 32'h104,       32'h108};
    tbl[9]  = '{0, 1, 0, 32'h0,         0, 32'h108,       1, 32'h104,       32'h108};
    tbl[10] = '{0, 0, 0, 32'h0,         1, 32'h10C,       1, 32'h108,       32'h10C};
    tbl[11] = '{0, 0, 0, 32'h0,         1, 32'h110,       1, 32'h10C,       32'h110};
    tbl[12] = '{0, 0, 1, 32'h2003,      1, 32'h2000,      0, 32'h0,         32'h4};
    tbl[13] = '{0, 0, 0, 32'h0,         1, 32'h2004,      1, 32'h2000,      32'h2004};
    tbl[14] = '{0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h4};
    tbl[15] = '{0, 0, 0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFFC, 32'h0};
    tbl[16] = '{0, 0, 0, 32'h0,         1, 32'h4,         1, 32'h0,         32'h4};

    lat_mode = 0;
    for (int i = 0; i < 17; i++) begin
      tick(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].t);
      check($sformatf("tbl%0d_req", i),   bus.IMem_Req,  tbl[i].e_req);
      check($sformatf("tbl%0d_addr", i),  bus.IMem_Addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_valid", i), valid,         tbl[i].e_valid);
      check($sformatf("tbl%0d_pc", i),    pc,            tbl[i].e_pc);
      check($sformatf("tbl%0d_pc4", i),   pc4,           tbl[i].e_pc4);
    end

    // Stall right after reset: 0x100 and 0x104 leave in order on release.
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 1, 0, 0);
    check("stall_req_low", bus.IMem_Req, 1'b0);
    check("stall_head", pc, 32'h100);
    tick(0, 0, 0, 0);
    check("release_pc0", pc, 32'h104);
    check("release_req", bus.IMem_Req, 1'b1);
    tick(0, 0, 0, 0);
    check("release_pc1", pc, 32'h108);

    // Redirect while a 3-cycle-latency request is outstanding.
    lat_mode = 3;
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    check("slow_req", bus.IMem_Req, 1'b1);
    check("slow_addr", bus.IMem_Addr, 32'h100);
    tick(0, 0, 1, 32'h400);
    check("drop_hold_req", bus.IMem_Req, 1'b1);
    check("drop_hold_addr", bus.IMem_Addr, 32'h100);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check("after_drop_req", bus.IMem_Req, 1'b1);
    check("after_drop_addr", bus.IMem_Addr, 32'h400);
    check("after_drop_valid", valid, 1'b0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    check("target_valid", valid, 1'b1);
    check("target_pc", pc, 32'h400);
    check("target_instr", instr, mem_word(32'h400));

    // Reset while a request is pending, then reset coinciding with an ack.
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 0);
    check("midrst_req", bus.IMem_Req, 1'b0);
    check("midrst_valid", valid, 1'b0);
    lat_mode = 0;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("ackrst_req", bus.IMem_Req, 1'b0);
    check("ackrst_valid", valid, 1'b0);
    tick(0, 0, 0, 0);
    check("restart_addr", bus.IMem_Addr, RST_PC);

    // Randomized traffic against the reference.
    lat_mode = -1;
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      bit          r, s, d;
      logic [31:0] t;
      r = ($urandom_range(199, 0) == 0);
      s = ($urandom_range(9, 0) < 3);
      d = ($urandom_range(99, 0) < 5);
      t = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      tick(r, s, d, t);
    end
    check("random_progress", (pops > 300), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the CPU pipeline, sitting directly upstream of the IF/ID stage register.
- Generates the PC sequence and issues single-outstanding requests on the instruction memory bus.
- Buffers returned instruction words in a 2-entry FIFO so memory returns are never lost while the pipeline is stalled.
- Presents {valid, instruction, PC} for the IF/ID register to capture; taken branches/jumps from execute redirect it.

## Interface
- RESET_PC, 32'h0000_0000, address of the first fetch after reset (bits [1:0] must be 0).
- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- o_IMem_Req  out  1  request valid; registered.
- o_IMem_Addr  out  32  word-aligned fetch address; registered; stable while o_IMem_Req is high.
- i_IMem_Ack  in  1  completes the outstanding request this cycle; may be high in the same cycle o_IMem_Req first rises.
- i_IMem_Data  in  32  instruction word, valid only when i_IMem_Ack is high.
- i_Stall  in  1  IF/ID register is not loading this cycle.
- i_Redirect  in  1  single-cycle control-flow redirect from execute.
- i_RedirectPC  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- o_Valid  out  1  FIFO head holds a live instruction.
- o_Instr  out  32  FIFO head instruction word.
- o_PC  out  32  FIFO head PC.
- o_PCPlus4  out  32  o_PC + 4, modulo 2^32.

## Operation
- **Reset values (edge where i_Rst=1):**
  - o_IMem_Req=0, o_IMem_Addr=RESET_PC.
  - FIFO count=0, so o_Valid=0.
  - o_Instr=0, o_PC=0, o_PCPlus4=4.
  - State S_RUN, next-PC=RESET_PC.
  - Reset overrides all other inputs, including mid-transaction; any ack for a request issued before reset is ignored.
- **States:**
  - S_RUN: normal operation.
  - S_DROP: a request was outstanding when a redirect arrived; its data must be discarded.
- **Issue rule.** At each edge, with no request outstanding after the edge, raise o_IMem_Req with o_IMem_Addr = next-PC only if FIFO count after this edge is ≤1. Then next-PC += 4, wrapping at 2^32.
  - "No request outstanding after the edge" means o_IMem_Req was low, or i_IMem_Ack=1 this cycle.
  - Consequence: a push never occurs at count 2, so the FIFO never overflows.
- **Ack in S_RUN.** Push {i_IMem_Data, o_IMem_Addr} into the FIFO.
- **Pop.** Occurs when o_Valid=1, i_Stall=0 and i_Redirect=0. Simultaneous push and pop keeps the count unchanged.
- **Redirect (priority over pop and push):**
  - FIFO count→0 at that edge.
  - Any ack in the same cycle is discarded.
  - next-PC = i_RedirectPC.
  - If a request remains outstanding (o_IMem_Req=1, i_IMem_Ack=0), go to S_DROP. o_IMem_Req and o_IMem_Addr stay unchanged until the ack.
- **In S_DROP:**
  - The ack is discarded with no push, and the state returns to S_RUN.
  - The issue rule applies at that same edge, so the request to the redirect target rises the next cycle.
  - A further redirect while in S_DROP only overwrites next-PC.
- The downstream IF/ID register loads {o_Valid, o_Instr, o_PC, o_PCPlus4} whenever i_Stall=0. When o_Valid=0 it captures a bubble.

## Timing
- **Zero-wait memory** (ack in the cycle req rises):
  - Reset released at edge E0 → req at cycle E0+1 → o_Valid from E0+2.
  - Sustained throughput is 1 instruction/cycle.
- **Redirect** sampled at edge R with no outstanding request: req to the target visible in cycle R+1; o_Valid earliest in cycle R+2.
- **Redirect with an N-cycle outstanding ack:** request to the target rises the cycle after the dropped ack.
- **Stall:** once count reaches 2 under a continuous stall, o_IMem_Req stays low. It re-rises the cycle after the first pop.
- All outputs are driven from registers only; there is no combinational path from i_IMem_Data to o_Instr.

## Structure
- **Shared package cpu_pkg** holds:
  - RESET_PC default;
  - fetch state encoding (S_RUN, S_DROP);
  - XLEN=32 width constant.
- **Sub-module fetch_fifo:** 2-entry, 64-bit-wide ({PC, instr}) synchronous FIFO.
  - Ports: push, pop, flush, count.
  - Flush takes priority over push and pop.
  - Head data is registered and reads 0 when empty.

## Test plan
- **Reset and sequential fetch.** Reset with RESET_PC=32'h100, zero-wait memory, no stall → addresses 0x100, 0x104, 0x108 on consecutive cycles; o_PC follows one cycle behind each ack; o_PCPlus4=o_PC+4.
- **Stall backpressure.** Hold i_Stall=1 for 6 cycles with zero-wait memory → count saturates at 2 and o_IMem_Req drops. On release, the instructions at 0x100 and 0x104 are popped in order with none lost or duplicated.
- **Redirect with no outstanding request.** Pulse i_Redirect with target 0x2003 → FIFO empties; the next request address is 0x2000; o_Valid is low for exactly one cycle.
- **Redirect during a slow ack.** Pulse i_Redirect to 0x400 with ack delayed 3 cycles → the dropped data never appears on o_Instr; the next request is 0x400 immediately after the dropped ack.
- **Redirect coinciding with ack and pop.** Assert i_Redirect, ack and pop together → ack data discarded, no pop counted, count=0.
- **Mid-transaction reset and wrap-around.** Assert i_Rst while a request is outstanding → req=0 and o_Valid=0 the next cycle. Separately, a redirect to 0xFFFF_FFFC followed by sequential fetch → next address 0x0000_0000; o_PCPlus4=0 for the 0xFFFF_FFFC entry.
